sig_debounce: RTL and testbench

Conditioning stage directly upstream of the change_detect edge detector. It synchronises an asynchronous, bouncy raw input into the clk domain and filters it. It then presents a clean, level-stable sig_out that drives change_detect.sig. As a result, change_detect sees exactly one transition per genuine input change. A companion glitch pulse and a stable flag support debug and verification visibility.

---
 rtl/debounce_pkg.sv | 26 ++
 rtl/sync_chain.sv | 42 ++++
 rtl/sig_debounce.sv | 135 +++++++++++++
 tb/tb_sig_debounce.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the input-conditioning (debounce) stage.
//   deb_state_t       : four-state debounce FSM encoding
//   DEB_SYNC_STAGES   : default synchroniser depth
//   DEB_STABLE_CYCLES : default number of cycles a new level must hold
//   deb_cnt_w()       : width of a counter able to hold 0..stable_cycles-1,
//                       with one bit of headroom
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } deb_state_t;

    localparam int DEB_SYNC_STAGES   = 2;
    localparam int DEB_STABLE_CYCLES = 4;

    function automatic int deb_cnt_w(input int stable_cycles);
        return $clog2(stable_cycles) + 1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Parameterised N-flop synchroniser for a single asynchronous input.
// Reusable for any asynchronous level signal entering the clk domain.
//   clk  in  1  capture clock, rising edge
//   rst  in  1  asynchronous active-high reset, clears every stage to 0
//   d    in  1  asynchronous input
//   q    out 1  synchronised output (last stage)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] w_sync_in;

    // Stage 0 captures the raw input; each later stage captures its
    // predecessor.
    assign w_sync_in[0] = d;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_link
            assign w_sync_in[gi] = r_sync[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= w_sync_in;
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/sig_debounce.sv
// -----------------------------------------------------------------------------
// sig_debounce
// Synchronises a bouncy asynchronous input and only lets a new level through
// once it has been seen for STABLE_CYCLES consecutive synchronised cycles.
// The clean level feeds a downstream edge detector, so every genuine input
// change becomes exactly one transition of sig_out.
//   clk     in  1  system clock, rising edge
//   rst     in  1  asynchronous active-high reset
//   raw_in  in  1  asynchronous, possibly bouncing input
//   sig_out out 1  debounced level (registered)
//   stable  out 1  high while no candidate change is pending (registered)
//   glitch  out 1  one-cycle pulse when a candidate change is abandoned
// -----------------------------------------------------------------------------
module sig_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEB_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEB_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic sig_out,
    output logic stable,
    output logic glitch
);

    // Derived only; the counter never needs to exceed STABLE_CYCLES-1.
    localparam int                CNT_W    = deb_cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             w_s;
    deb_state_t       r_state;
    deb_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_sig_out;
    logic             w_sig_out_next;
    logic             r_stable;
    logic             w_stable_next;
    logic             r_glitch;
    logic             w_glitch_next;

    // raw_in only reaches the FSM through the synchroniser.
    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (w_s)
    );

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_sig_out_next = r_sig_out;
        w_glitch_next  = 1'b0;

        case (r_state)
            IDLE_LOW: begin
                if (w_s) begin
                    // First cycle of the candidate already counts.
                    w_state_next = CHECK_HIGH;
                    w_cnt_next   = CNT_ONE;
                end else begin
                    w_cnt_next   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!w_s) begin
                    w_state_next  = IDLE_LOW;
                    w_cnt_next    = '0;
                    w_glitch_next = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next   = IDLE_HIGH;
                    w_sig_out_next = 1'b1;
                    w_cnt_next     = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!w_s) begin
                    w_state_next = CHECK_LOW;
                    w_cnt_next   = CNT_ONE;
                end else begin
                    w_cnt_next   = '0;
                end
            end
            CHECK_LOW: begin
                if (w_s) begin
                    w_state_next  = IDLE_HIGH;
                    w_cnt_next    = '0;
                    w_glitch_next = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next   = IDLE_LOW;
                    w_sig_out_next = 1'b0;
                    w_cnt_next     = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = IDLE_LOW;
                w_cnt_next   = '0;
            end
        endcase

        // stable is registered alongside the state so it is glitch-free.
        w_stable_next = (w_state_next == IDLE_LOW) || (w_state_next == IDLE_HIGH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE_LOW;
            r_cnt     <= '0;
            r_sig_out <= 1'b0;
            r_stable  <= 1'b1;
            r_glitch  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_sig_out <= w_sig_out_next;
            r_stable  <= w_stable_next;
            r_glitch  <= w_glitch_next;
        end
    end

    assign sig_out = r_sig_out;
    assign stable  = r_stable;
    assign glitch  = r_glitch;

endmodule

// File: tb/tb_sig_debounce.sv
// -----------------------------------------------------------------------------
// tb_sig_debounce
// Scoreboarded bench for sig_debounce. Stimulus drives raw_in on the falling
// edge, runs a run-length reference model for the following rising edge and
// queues the expected outputs; a monitor pops and compares shortly after each
// rising edge. A small edge detector stands in for change_detect.
// -----------------------------------------------------------------------------
module tb_sig_debounce;

    localparam int SYNC = 2;
    localparam int STAB = 4;

    logic clk = 1'b0;
    logic rst;
    logic raw_in;
    logic sig_out;
    logic stable;
    logic glitch;

    sig_debounce #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STAB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raw_in  (raw_in),
        .sig_out (sig_out),
        .stable  (stable),
        .glitch  (glitch)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic sig;
        logic stb;
        logic glt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: history of sampled raw values since reset, the
    // accepted level, and how long the synchronised input has disagreed.
    logic m_hist[$];
    logic m_out     = 1'b0;
    int   m_run     = 0;
    int   m_toggles = 0;

    // Detection / observation counters kept by the monitor.
    int edge_idx  = 0;
    int det_count = 0;
    int last_det  = -1;
    int glitch_cnt = 0;
    logic prev_sig = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Outputs after one rising edge at which raw value r is sampled.
    task automatic model_edge(input logic r, output exp_t e);
        logic s;
        logic g;
        if (rst) begin
            m_hist.delete();
            m_out = 1'b0;
            m_run = 0;
            e.sig = 1'b0;
            e.stb = 1'b1;
            e.glt = 1'b0;
        end else begin
            // The FSM sees the sample taken SYNC edges earlier (0 after reset).
            s = (m_hist.size() >= SYNC) ? m_hist[m_hist.size() - SYNC] : 1'b0;
            m_hist.push_back(r);
            if (m_hist.size() > 16) void'(m_hist.pop_front());
            g = 1'b0;
            if (s != m_out) begin
                m_run++;
                if (m_run == STAB) begin
                    m_out = s;
                    m_run = 0;
                    m_toggles++;
                end
            end else begin
                if (m_run > 0) g = 1'b1;
                m_run = 0;
            end
            e.sig = m_out;
            e.stb = (m_run == 0);
            e.glt = g;
        end
    endtask

    // Drive one value for one clock; returns 2ns after the rising edge.
    task automatic step(input logic v);
        exp_t e;
        @(negedge clk);
        raw_in = v;
        model_edge(v, e);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: scoreboard compare plus change_detect stand-in.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edge_idx++;
            if (glitch === 1'b1) glitch_cnt++;
            if (sig_out !== prev_sig) begin
                det_count++;
                if (last_det >= 0)
                    chk("det_spacing_ok", 32'((edge_idx - last_det) >= STAB), 32'd1);
                last_det = edge_idx;
            end
            prev_sig = sig_out;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sig_out", 32'(sig_out), 32'(e.sig));
                chk("stable",  32'(stable),  32'(e.stb));
                chk("glitch",  32'(glitch),  32'(e.glt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0;
        logic v;
        int len;

        // 1. Reset held with raw_in high.
        rst    = 1'b1;
        raw_in = 1'b1;
        #2;
        chk("rst_sig_out", 32'(sig_out), 32'd0);
        chk("rst_stable",  32'(stable),  32'd1);
        chk("rst_glitch",  32'(glitch),  32'd0);
        #5;
        chk("rst_sig_out_after_edge", 32'(sig_out), 32'd0);
        chk("rst_stable_after_edge",  32'(stable),  32'd1);
        chk("rst_glitch_after_edge",  32'(glitch),  32'd0);
        #1 raw_in = 1'b0;
        #2 rst = 1'b0;

        // 2. Clean rise: sig_out follows 5 edges after the first sampling edge.
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int j = 1; j <= 8; j++) begin
            step(1'b1);
            $display("clean_rise step %0d sig_out=%0b stable=%0b glitch=%0b", j, sig_out, stable, glitch);
            chk("t2_sig_out", 32'(sig_out), 32'(j >= 6));
            chk("t2_stable",  32'(stable),  32'(!(j >= 3 && j <= 5)));
            chk("t2_glitch",  32'(glitch),  32'd0);
        end

        // 3. Short glitch after settling low.
        for (int i = 0; i < 8; i++) step(1'b0);
        g0 = glitch_cnt;
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 8; i++) step(1'b0);
        chk("t3_glitch_pulses", 32'(glitch_cnt - g0), 32'd1);
        chk("t3_sig_out", 32'(sig_out), 32'd0);
        chk("t3_stable",  32'(stable),  32'd1);
        $display("short_glitch pulses=%0d sig_out=%0b", glitch_cnt - g0, sig_out);

        // 4. Bounce 1,0,1,0 then settle high.
        g0 = glitch_cnt;
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        for (int j = 1; j <= 8; j++) begin
            step(1'b1);
            chk("t4_sig_out", 32'(sig_out), 32'(j >= 6));
        end
        chk("t4_glitch_pulses", 32'(glitch_cnt - g0), 32'd2);
        $display("bounce pulses=%0d sig_out=%0b", glitch_cnt - g0, sig_out);

        // 5. Asynchronous reset in the middle of a rising check.
        for (int i = 0; i < 8; i++) step(1'b0);
        for (int j = 1; j <= 4; j++) step(1'b1);
        chk("t5_pre_stable", 32'(stable), 32'd0);
        g0 = glitch_cnt;
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_sig_out", 32'(sig_out), 32'd0);
        chk("t5_rst_stable",  32'(stable),  32'd1);
        chk("t5_rst_glitch",  32'(glitch),  32'd0);
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            step(1'b1);
            chk("t5_sig_out", 32'(sig_out), 32'(j >= 6));
        end
        chk("t5_no_glitch", 32'(glitch_cnt - g0), 32'd0);
        $display("reset_mid_check sig_out=%0b", sig_out);

        // 6. Random raw_in feeding the edge-detector stand-in.
        for (int i = 0; i < 25; i++) step(1'(($urandom) & 1));
        v = ~raw_in;
        for (int i = 0; i < 10; i++) step(v);
        for (int r = 0; r < 40; r++) begin
            v   = 1'(($urandom) & 1);
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) step(v);
        end
        for (int i = 0; i < 10; i++) step(v);
        #5;
        chk("det_count", 32'(det_count), 32'(m_toggles));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("chain detections=%0d expected=%0d", det_count, m_toggles);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
